// File: rtl/gps_ack_peak_search.sv
// gps_ack_peak_search
// Tracks, per satellite lane, the largest and second-largest correlation
// magnitude over one full code-phase sweep, then streams one result beat per
// lane (best phase, peak, runner-up, detect decision) to the acquisition
// controller over a valid/ready handshake.
module gps_ack_peak_search #(
   parameter int unsigned CODE_LEN    = 1023,
   parameter logic [11:0] PEAK_THRESH = 12'd200,
   parameter logic [11:0] MARGIN      = 12'd40
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        corr_complete,
   input  logic [9:0]  code_phase,
   input  logic [5:0]  sat0,
   input  logic [5:0]  sat1,
   input  logic [5:0]  sat2,
   input  logic [5:0]  sat3,
   input  logic [11:0] integrator_0,
   input  logic [11:0] integrator_1,
   input  logic [11:0] integrator_2,
   input  logic [11:0] integrator_3,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [5:0]  res_sat,
   output logic [9:0]  res_phase,
   output logic [11:0] res_peak,
   output logic [11:0] res_second,
   output logic        res_detect,
   output logic        res_last,
   output logic        busy,
   output logic        overrun,
   output logic        seq_err
);

   localparam logic [9:0] LAST_PHASE = 10'(CODE_LEN - 1);

   typedef enum logic {S_IDLE, S_ACC}  acc_state_t;
   typedef enum logic {R_IDLE, R_SEND} rep_state_t;

   acc_state_t  acc_state;
   rep_state_t  rep_state;
   logic [9:0]  exp_phase;
   logic [1:0]  idx;

   // Running per-lane sweep state
   logic [5:0]  sat_q        [4];
   logic [11:0] peak_q       [4];
   logic [11:0] second_q     [4];
   logic [9:0]  peak_phase_q [4];

   // Report buffer, one entry per lane
   logic [5:0]  buf_sat      [4];
   logic [9:0]  buf_phase    [4];
   logic [11:0] buf_peak     [4];
   logic [11:0] buf_second   [4];
   logic        buf_detect   [4];

   // Inputs gathered into lane arrays, plus next-state lane values
   logic [5:0]  in_sat       [4];
   logic [11:0] in_val       [4];
   logic [11:0] nxt_peak     [4];
   logic [11:0] nxt_second   [4];
   logic [9:0]  nxt_phase    [4];
   logic        nxt_detect   [4];

   logic sat_ok;
   logic phase_ok;
   logic acc_hit;
   logic final_hit;
   logic xfer;
   logic buf_free;
   logic snap;

   // Lane gathering, peak/second update rule and snapshot/handshake qualifiers
   always_comb begin
      in_sat[0] = sat0;
      in_sat[1] = sat1;
      in_sat[2] = sat2;
      in_sat[3] = sat3;
      in_val[0] = integrator_0;
      in_val[1] = integrator_1;
      in_val[2] = integrator_2;
      in_val[3] = integrator_3;
      sat_ok    = 1'b1;
      for (int unsigned i = 0; i < 4; i++) begin
         if (in_sat[i] != sat_q[i]) sat_ok = 1'b0;
         nxt_peak[i]   = peak_q[i];
         nxt_second[i] = second_q[i];
         nxt_phase[i]  = peak_phase_q[i];
         if (in_val[i] > peak_q[i]) begin
            nxt_second[i] = peak_q[i];
            nxt_peak[i]   = in_val[i];
            nxt_phase[i]  = code_phase;
         end else if (in_val[i] > second_q[i]) begin
            nxt_second[i] = in_val[i];
         end
         nxt_detect[i] = (nxt_peak[i] >= PEAK_THRESH) &&
                         ((nxt_peak[i] - nxt_second[i]) >= MARGIN);
      end
      phase_ok  = (code_phase == exp_phase);
      acc_hit   = (acc_state == S_ACC) && corr_complete && phase_ok && sat_ok;
      final_hit = acc_hit && (code_phase == LAST_PHASE);
      xfer      = res_valid && res_ready;
      // buffer counts as free on the edge its last beat is accepted
      buf_free  = (rep_state == R_IDLE) || (xfer && (idx == 2'd3));
      snap      = final_hit && buf_free;
   end

   // Sweep accumulation FSM with sticky sequence/overrun flags
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_state <= S_IDLE;
         exp_phase <= '0;
         seq_err   <= 1'b0;
         overrun   <= 1'b0;
         for (int unsigned i = 0; i < 4; i++) begin
            sat_q[i]        <= '0;
            peak_q[i]       <= '0;
            second_q[i]     <= '0;
            peak_phase_q[i] <= '0;
         end
      end else begin
         case (acc_state)
            S_IDLE: begin
               if (corr_complete && (code_phase == '0)) begin
                  for (int unsigned i = 0; i < 4; i++) begin
                     sat_q[i]        <= in_sat[i];
                     peak_q[i]       <= in_val[i];
                     second_q[i]     <= '0;
                     peak_phase_q[i] <= '0;
                  end
                  exp_phase <= 10'd1;
                  acc_state <= S_ACC;
               end
            end
            S_ACC: begin
               if (corr_complete) begin
                  if (phase_ok && sat_ok) begin
                     for (int unsigned i = 0; i < 4; i++) begin
                        peak_q[i]       <= nxt_peak[i];
                        second_q[i]     <= nxt_second[i];
                        peak_phase_q[i] <= nxt_phase[i];
                     end
                     exp_phase <= exp_phase + 10'd1;
                     if (final_hit) begin
                        acc_state <= S_IDLE;
                        if (!buf_free) overrun <= 1'b1;
                     end
                  end else begin
                     seq_err   <= 1'b1;
                     acc_state <= S_IDLE;
                  end
               end
            end
            default: acc_state <= S_IDLE;
         endcase
      end
   end

   // Report buffer capture and lane-by-lane result streaming FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         rep_state <= R_IDLE;
         idx       <= '0;
         res_valid <= 1'b0;
         for (int unsigned i = 0; i < 4; i++) begin
            buf_sat[i]    <= '0;
            buf_phase[i]  <= '0;
            buf_peak[i]   <= '0;
            buf_second[i] <= '0;
            buf_detect[i] <= 1'b0;
         end
      end else begin
         if (snap) begin
            for (int unsigned i = 0; i < 4; i++) begin
               buf_sat[i]    <= sat_q[i];
               buf_phase[i]  <= nxt_phase[i];
               buf_peak[i]   <= nxt_peak[i];
               buf_second[i] <= nxt_second[i];
               buf_detect[i] <= nxt_detect[i];
            end
         end
         case (rep_state)
            R_IDLE: begin
               if (snap) begin
                  rep_state <= R_SEND;
                  idx       <= '0;
                  res_valid <= 1'b1;
               end
            end
            R_SEND: begin
               if (xfer) begin
                  if (idx == 2'd3) begin
                     // a snapshot landing on the freeing edge restarts without a bubble
                     if (snap) begin
                        idx       <= '0;
                        res_valid <= 1'b1;
                     end else begin
                        rep_state <= R_IDLE;
                        idx       <= '0;
                        res_valid <= 1'b0;
                     end
                  end else begin
                     idx <= idx + 2'd1;
                  end
               end
            end
            default: rep_state <= R_IDLE;
         endcase
      end
   end

   assign res_sat    = buf_sat[idx];
   assign res_phase  = buf_phase[idx];
   assign res_peak   = buf_peak[idx];
   assign res_second = buf_second[idx];
   assign res_detect = buf_detect[idx];
   assign res_last   = res_valid && (idx == 2'd3);
   assign busy       = (acc_state == S_ACC);

endmodule

// File: tb/tb_gps_ack_peak_search.sv
// Directed bench for gps_ack_peak_search: drives whole sweeps, keeps the raw
// sample table, derives expected beats as max / first-index-of-max / max of
// the rest, and checks every presented beat against that model.
module tb_gps_ack_peak_search;

   localparam int CL = 1023;

   logic        clk = 1'b0;
   logic        rst;
   logic        corr_complete;
   logic [9:0]  code_phase;
   logic [5:0]  sat0, sat1, sat2, sat3;
   logic [11:0] integrator_0, integrator_1, integrator_2, integrator_3;
   logic        res_valid, res_ready;
   logic [5:0]  res_sat;
   logic [9:0]  res_phase;
   logic [11:0] res_peak, res_second;
   logic        res_detect, res_last, busy, overrun, seq_err;

   always #5 clk = ~clk;

   gps_ack_peak_search #(.CODE_LEN(1023), .PEAK_THRESH(12'd200), .MARGIN(12'd40)) dut (
      .clk(clk), .rst(rst), .corr_complete(corr_complete), .code_phase(code_phase),
      .sat0(sat0), .sat1(sat1), .sat2(sat2), .sat3(sat3),
      .integrator_0(integrator_0), .integrator_1(integrator_1),
      .integrator_2(integrator_2), .integrator_3(integrator_3),
      .res_valid(res_valid), .res_ready(res_ready), .res_sat(res_sat),
      .res_phase(res_phase), .res_peak(res_peak), .res_second(res_second),
      .res_detect(res_detect), .res_last(res_last), .busy(busy),
      .overrun(overrun), .seq_err(seq_err)
   );

   typedef struct {
      int sat;
      int phase;
      int peak;
      int second;
      int detect;
      int last;
   } beat_t;

   beat_t exp_q[$];
   beat_t cap [4];
   int    xfers  = 0;
   int    checks = 0;
   int    errors = 0;
   int    vals [4][CL];

   task automatic chk(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
      end
   endtask

   function automatic int gen(input int pat, input int lane, input int ph);
      case (pat)
         0:       return (lane == 0) ? ph : 0;
         1:       return (lane == 2 && ph == 317) ? 500 : 50;
         2:       return (lane == 1 && (ph == 10 || ph == 20)) ? 300 : 0;
         3:       return int'($urandom_range(0, 4095));
         default: return (ph == 700 + lane) ? lane * 100 + 900 : lane * 100 + ph % 7;
      endcase
   endfunction

   task automatic drive_phase(input int ph, input int pat, input int sb);
      int v [4];
      @(posedge clk); #1;
      for (int l = 0; l < 4; l++) begin
         v[l] = gen(pat, l, ph);
         vals[l][ph] = v[l];
      end
      corr_complete = 1'b1;
      code_phase    = 10'(ph);
      sat0 = 6'(sb);     sat1 = 6'(sb + 1);
      sat2 = 6'(sb + 2); sat3 = 6'(sb + 3);
      integrator_0 = 12'(v[0]); integrator_1 = 12'(v[1]);
      integrator_2 = 12'(v[2]); integrator_3 = 12'(v[3]);
   endtask

   task automatic end_pulse();
      @(posedge clk); #1;
      corr_complete = 1'b0;
   endtask

   // Expected result per lane from the whole sample table
   task automatic push_model(input int sb);
      beat_t b;
      int pk, pp, sc;
      for (int l = 0; l < 4; l++) begin
         pk = vals[l][0]; pp = 0;
         for (int ph = 1; ph < CL; ph++)
            if (vals[l][ph] > pk) begin pk = vals[l][ph]; pp = ph; end
         sc = 0;
         for (int ph = 0; ph < CL; ph++)
            if (ph != pp && vals[l][ph] > sc) sc = vals[l][ph];
         b.sat = sb + l; b.phase = pp; b.peak = pk; b.second = sc;
         b.detect = (pk >= 200 && pk - sc >= 40) ? 1 : 0;
         b.last = (l == 3) ? 1 : 0;
         exp_q.push_back(b);
      end
   endtask

   task automatic run_sweep(input int pat, input int sb, input bit expect_report);
      for (int ph = 0; ph < CL; ph++) begin
         drive_phase(ph, pat, sb);
         if (ph == 500) chk("busy_mid", busy, 1);
      end
      end_pulse();
      chk("busy_end", busy, 0);
      if (expect_report) begin
         chk("latency_valid", res_valid, 1);
         push_model(sb);
      end
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(posedge clk); n++;
      end
      chk("drain_timeout", exp_q.size(), 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   // Compare every presented beat against the model queue
   always @(negedge clk) begin
      if (!rst && res_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_valid", 1, 0);
         end else begin
            chk("res_sat",    res_sat,    exp_q[0].sat);
            chk("res_phase",  res_phase,  exp_q[0].phase);
            chk("res_peak",   res_peak,   exp_q[0].peak);
            chk("res_second", res_second, exp_q[0].second);
            chk("res_detect", res_detect, exp_q[0].detect);
            chk("res_last",   res_last,   exp_q[0].last);
            if (res_ready) begin
               cap[xfers % 4] = '{sat: res_sat, phase: res_phase, peak: res_peak,
                                  second: res_second, detect: res_detect, last: res_last};
               xfers++;
               void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int x0;
      int n;
      rst = 1'b1; corr_complete = 1'b0; code_phase = '0; res_ready = 1'b1;
      sat0 = '0; sat1 = '0; sat2 = '0; sat3 = '0;
      integrator_0 = '0; integrator_1 = '0; integrator_2 = '0; integrator_3 = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", res_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_seq_err", seq_err, 0);
      chk("rst_peak", res_peak, 0);
      chk("rst_last", res_last, 0);
      rst = 1'b0;

      // stray non-zero phase while idle is ignored
      drive_phase(5, 0, 1);
      end_pulse();
      chk("stray_busy", busy, 0);
      chk("stray_seq_err", seq_err, 0);

      // ramp on lane 0
      run_sweep(0, 1, 1'b1);
      wait_drain();
      chk("ramp_peak", cap[0].peak, 1022);
      chk("ramp_phase", cap[0].phase, 1022);
      chk("ramp_second", cap[0].second, 1021);
      chk("ramp_detect", cap[0].detect, 0);
      chk("ramp_sat", cap[0].sat, 1);
      chk("ramp_last", cap[3].last, 1);

      // single spike on lane 2
      run_sweep(1, 10, 1'b1);
      wait_drain();
      chk("spike_peak", cap[2].peak, 500);
      chk("spike_phase", cap[2].phase, 317);
      chk("spike_second", cap[2].second, 50);
      chk("spike_detect", cap[2].detect, 1);
      chk("spike_l0_peak", cap[0].peak, 50);
      chk("spike_l0_phase", cap[0].phase, 0);
      chk("spike_l0_detect", cap[0].detect, 0);

      // tie on lane 1
      run_sweep(2, 20, 1'b1);
      wait_drain();
      chk("tie_peak", cap[1].peak, 300);
      chk("tie_phase", cap[1].phase, 10);
      chk("tie_second", cap[1].second, 300);
      chk("tie_detect", cap[1].detect, 0);

      // backpressure: stall 5 cycles then toggle ready
      res_ready = 1'b0;
      x0 = xfers;
      run_sweep(3, 30, 1'b1);
      repeat (5) @(posedge clk);
      #1;
      chk("bp_stalled_beats", xfers - x0, 0);
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk); #1;
         res_ready = ~res_ready;
         n++;
      end
      chk("bp_beats", xfers - x0, 4);
      res_ready = 1'b1;
      wait_drain();

      // sequence error: 0,1,2,4
      drive_phase(0, 4, 40);
      drive_phase(1, 4, 40);
      drive_phase(2, 4, 40);
      drive_phase(4, 4, 40);
      end_pulse();
      chk("seq_err_set", seq_err, 1);
      chk("seq_busy", busy, 0);
      repeat (20) @(posedge clk);
      #1;
      chk("seq_no_valid", res_valid, 0);
      run_sweep(4, 41, 1'b1);
      wait_drain();
      chk("seq_clean_peak", cap[0].peak, 900);
      chk("seq_clean_phase", cap[0].phase, 700);
      chk("seq_clean_second", cap[0].second, 6);
      chk("seq_clean_detect", cap[0].detect, 1);
      chk("seq_clean_l3_peak", cap[3].peak, 1200);
      chk("seq_err_sticky", seq_err, 1);

      // overrun: two sweeps while consumer stalled
      res_ready = 1'b0;
      run_sweep(1, 50, 1'b1);
      run_sweep(2, 51, 1'b0);
      chk("overrun_set", overrun, 1);
      res_ready = 1'b1;
      wait_drain();
      chk("overrun_first_sat", cap[2].sat, 52);
      chk("overrun_first_peak", cap[2].peak, 500);
      repeat (10) @(posedge clk);
      #1;
      chk("overrun_no_extra", res_valid, 0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset_overrun", overrun, 0);
      chk("reset_seq_err", seq_err, 0);

      // reset mid-report drops the pending results
      res_ready = 1'b0;
      run_sweep(0, 60, 1'b0);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      res_ready = 1'b1;
      chk("midrst_valid", res_valid, 0);
      repeat (10) @(posedge clk);
      #1;
      chk("midrst_no_beats", res_valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
